// File: rtl/mult5_share_arbiter.sv
// Round-robin front end for one shared 5x5 multiplier.
// Operands are registered toward the multiplier and the product comes back over valid/ready.
module mult5_share_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2,
    parameter int OP_W    = 5
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_REQ-1:0]      req_valid,
    input  logic [OP_W*NUM_REQ-1:0] req_a,
    input  logic [OP_W*NUM_REQ-1:0] req_b,
    output logic [NUM_REQ-1:0]      req_ready,
    output logic [OP_W-1:0]         mul_a,
    output logic [OP_W-1:0]         mul_b,
    input  logic [2*OP_W-1:0]       mul_z,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [ID_W-1:0]         rsp_id,
    output logic [2*OP_W-1:0]       rsp_z,
    output logic                    busy
);

    typedef enum logic [1:0] {IDLE, CALC, RESP} state_t;

    state_t          state, state_nx;
    logic [ID_W-1:0] rr_ptr, id_q, win, ptr_nx;
    logic            found, arb, grant;

    // Two passes: indices at/after the pointer first, then wrap to the low ones.
    always_comb begin
        found = 1'b0;
        win   = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (!found && req_valid[j] && ID_W'(j) >= rr_ptr) begin
                found = 1'b1;
                win   = ID_W'(j);
            end
        end
        for (int j = 0; j < NUM_REQ; j++) begin
            if (!found && req_valid[j]) begin
                found = 1'b1;
                win   = ID_W'(j);
            end
        end
    end

    assign ptr_nx = (win == ID_W'(NUM_REQ - 1)) ? '0 : win + 1'b1;

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        arb       = 1'b0;
        req_ready = '0;
        unique case (state)
            IDLE: arb = 1'b1;
            CALC: state_nx = RESP;
            RESP: begin
                if (rsp_ready) begin
                    arb      = 1'b1;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
        grant = arb && found && rst_n;
        if (grant) begin
            state_nx       = CALC;
            req_ready[win] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_ptr    <= '0;
            id_q      <= '0;
            mul_a     <= '0;
            mul_b     <= '0;
            rsp_z     <= '0;
            rsp_id    <= '0;
            rsp_valid <= 1'b0;
        end else begin
            if (grant) begin
                mul_a  <= req_a[int'(win)*OP_W +: OP_W];
                mul_b  <= req_b[int'(win)*OP_W +: OP_W];
                id_q   <= win;
                rr_ptr <= ptr_nx;
            end
            if (state == CALC) begin
                rsp_z     <= mul_z;
                rsp_id    <= id_q;
                rsp_valid <= 1'b1;
            end else if (state == RESP && rsp_ready) begin
                rsp_valid <= 1'b0;
            end
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_mult5_share_arbiter.sv
// Directed bench for mult5_share_arbiter with a behavioural 5x5 multiplier.
// Inputs change on the falling edge; outputs are checked 1ns later.
module tb_mult5_share_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [19:0] req_a, req_b;
    logic [3:0]  req_ready;
    logic [4:0]  mul_a, mul_b;
    logic [9:0]  mul_z;
    logic        rsp_valid, rsp_ready;
    logic [1:0]  rsp_id;
    logic [9:0]  rsp_z;
    logic        busy;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    assign mul_z = {5'b0, mul_a} * {5'b0, mul_b};

    mult5_share_arbiter #(.NUM_REQ(4), .ID_W(2), .OP_W(5)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
        .req_ready(req_ready),
        .mul_a(mul_a), .mul_b(mul_b), .mul_z(mul_z),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_z(rsp_z), .busy(busy)
    );

    task automatic nx();
        @(negedge clk);
    endtask

    task automatic set_op(input int k, input logic [4:0] a, input logic [4:0] b);
        req_a[k*5 +: 5] = a;
        req_b[k*5 +: 5] = b;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req_valid = 4'b1111; rsp_ready = 1'b0;
        req_a = '0; req_b = '0;
        nx(); #1;
        n_cmp++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL reset_ready got %b want 0000", req_ready); end
        n_cmp++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", rsp_valid); end
        n_cmp++; if (rsp_z !== 10'd0) begin n_fail++; $display("FAIL reset_z got %0d want 0", rsp_z); end
        n_cmp++; if (rsp_id !== 2'd0) begin n_fail++; $display("FAIL reset_id got %0d want 0", rsp_id); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
        n_cmp++; if (mul_a !== 5'd0 || mul_b !== 5'd0) begin n_fail++; $display("FAIL reset_mul got %0d,%0d want 0,0", mul_a, mul_b); end
        req_valid = 4'b0000; rst_n = 1'b1;
    endtask

    task automatic test_single();
        nx(); set_op(2, 5'd31, 5'd31); req_valid = 4'b0100; rsp_ready = 1'b0; #1;
        n_cmp++; if (req_ready !== 4'b0100) begin n_fail++; $display("FAIL single_grant got %b want 0100", req_ready); end
        nx(); req_valid = 4'b0000; #1;
        n_cmp++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL single_calc_ready got %b want 0000", req_ready); end
        n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL single_busy got %b want 1", busy); end
        n_cmp++; if (mul_a !== 5'd31 || mul_b !== 5'd31) begin n_fail++; $display("FAIL single_mul got %0d,%0d want 31,31", mul_a, mul_b); end
        n_cmp++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL single_early_valid got %b want 0", rsp_valid); end
        nx(); rsp_ready = 1'b1; #1;
        n_cmp++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid got %b want 1", rsp_valid); end
        n_cmp++; if (rsp_z !== 10'd961) begin n_fail++; $display("FAIL single_z got %0d want 961", rsp_z); end
        n_cmp++; if (rsp_id !== 2'd2) begin n_fail++; $display("FAIL single_id got %0d want 2", rsp_id); end
        nx(); #1;
        n_cmp++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL single_drain got valid=%b busy=%b want 0,0", rsp_valid, busy); end
    endtask

    task automatic test_round_robin();
        logic [9:0] exp_z [4];
        logic [3:0] exp_g;
        exp_z[0] = 10'd30; exp_z[1] = 10'd44; exp_z[2] = 10'd60; exp_z[3] = 10'd78;
        nx(); rst_n = 1'b0;
        nx(); rst_n = 1'b1;
        for (int k = 0; k < 4; k++) set_op(k, 5'(k + 3), 5'(k + 10));
        rsp_ready = 1'b1; req_valid = 4'b1111; #1;
        n_cmp++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL rr_first got %b want 0001", req_ready); end
        for (int g = 0; g < 6; g++) begin
            nx(); #1;
            n_cmp++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL rr_calc[%0d] got %b want 0000", g, req_ready); end
            nx(); if (g == 5) req_valid = 4'b0000; #1;
            n_cmp++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL rr_valid[%0d] got %b want 1", g, rsp_valid); end
            n_cmp++; if (rsp_id !== 2'(g % 4)) begin n_fail++; $display("FAIL rr_id[%0d] got %0d want %0d", g, rsp_id, g % 4); end
            n_cmp++; if (rsp_z !== exp_z[g % 4]) begin n_fail++; $display("FAIL rr_z[%0d] got %0d want %0d", g, rsp_z, exp_z[g % 4]); end
            if (g < 5) begin
                exp_g = 4'b0001 << ((g + 1) % 4);
                n_cmp++; if (req_ready !== exp_g) begin n_fail++; $display("FAIL rr_grant[%0d] got %b want %b", g, req_ready, exp_g); end
            end
        end
        nx(); #1;
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rr_drain got busy=%b want 0", busy); end
    endtask

    task automatic test_wrap();
        set_op(0, 5'd2, 5'd3); set_op(3, 5'd9, 5'd9);
        nx(); req_valid = 4'b1000; #1;
        n_cmp++; if (req_ready !== 4'b1000) begin n_fail++; $display("FAIL wrap_g3 got %b want 1000", req_ready); end
        nx(); req_valid = 4'b1001; #1;
        n_cmp++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL wrap_calc got %b want 0000", req_ready); end
        nx(); #1;
        n_cmp++; if (rsp_id !== 2'd3 || rsp_z !== 10'd81) begin n_fail++; $display("FAIL wrap_rsp3 got id=%0d z=%0d want 3,81", rsp_id, rsp_z); end
        n_cmp++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL wrap_g0 got %b want 0001", req_ready); end
        nx(); req_valid = 4'b1000; #1;
        n_cmp++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL wrap_calc2 got %b want 0000", req_ready); end
        nx(); #1;
        n_cmp++; if (rsp_id !== 2'd0 || rsp_z !== 10'd6) begin n_fail++; $display("FAIL wrap_rsp0 got id=%0d z=%0d want 0,6", rsp_id, rsp_z); end
        n_cmp++; if (req_ready !== 4'b1000) begin n_fail++; $display("FAIL wrap_g3b got %b want 1000", req_ready); end
        nx(); req_valid = 4'b0000;
        nx(); nx(); #1;
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL wrap_drain got busy=%b want 0", busy); end
    endtask

    task automatic test_backpressure();
        set_op(0, 5'd7, 5'd9); set_op(1, 5'd4, 5'd4); set_op(2, 5'd6, 5'd6);
        rsp_ready = 1'b0;
        nx(); req_valid = 4'b0001; #1;
        n_cmp++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL bp_grant got %b want 0001", req_ready); end
        nx(); req_valid = 4'b0110; #1;
        n_cmp++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL bp_calc got %b want 0000", req_ready); end
        for (int i = 0; i < 5; i++) begin
            nx(); #1;
            n_cmp++; if (rsp_valid !== 1'b1 || busy !== 1'b1) begin n_fail++; $display("FAIL bp_valid[%0d] got valid=%b busy=%b want 1,1", i, rsp_valid, busy); end
            n_cmp++; if (rsp_z !== 10'd63 || rsp_id !== 2'd0) begin n_fail++; $display("FAIL bp_hold[%0d] got z=%0d id=%0d want 63,0", i, rsp_z, rsp_id); end
            n_cmp++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL bp_ready[%0d] got %b want 0000", i, req_ready); end
        end
        nx(); rsp_ready = 1'b1; #1;
        n_cmp++; if (req_ready !== 4'b0010) begin n_fail++; $display("FAIL bp_release got %b want 0010", req_ready); end
        nx(); req_valid = 4'b0000;
        nx(); #1;
        n_cmp++; if (rsp_z !== 10'd16 || rsp_id !== 2'd1) begin n_fail++; $display("FAIL bp_next got z=%0d id=%0d want 16,1", rsp_z, rsp_id); end
        nx();
    endtask

    task automatic test_corners();
        logic [4:0] ca [4];
        logic [4:0] cb [4];
        logic [9:0] cz [4];
        ca[0] = 5'd0;  cb[0] = 5'd17; cz[0] = 10'd0;
        ca[1] = 5'd1;  cb[1] = 5'd31; cz[1] = 10'd31;
        ca[2] = 5'd16; cb[2] = 5'd16; cz[2] = 10'd256;
        ca[3] = 5'd31; cb[3] = 5'd1;  cz[3] = 10'd31;
        rsp_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            nx(); set_op(1, ca[i], cb[i]); req_valid = 4'b0010; #1;
            n_cmp++; if (req_ready !== 4'b0010) begin n_fail++; $display("FAIL corner_grant[%0d] got %b want 0010", i, req_ready); end
            nx(); req_valid = 4'b0000;
            nx(); #1;
            n_cmp++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd1) begin n_fail++; $display("FAIL corner_rsp[%0d] got valid=%b id=%0d want 1,1", i, rsp_valid, rsp_id); end
            n_cmp++; if (rsp_z !== cz[i]) begin n_fail++; $display("FAIL corner_z[%0d] got %0d want %0d", i, rsp_z, cz[i]); end
        end
    endtask

    task automatic test_reset_calc();
        nx(); set_op(2, 5'd5, 5'd5); req_valid = 4'b0100; #1;
        n_cmp++; if (req_ready !== 4'b0100) begin n_fail++; $display("FAIL rc_grant got %b want 0100", req_ready); end
        nx(); req_valid = 4'b1111; rst_n = 1'b0; #1;
        n_cmp++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL rc_ready_low got %b want 0000", req_ready); end
        nx(); rst_n = 1'b1; #1;
        n_cmp++; if (rsp_valid !== 1'b0 || rsp_z !== 10'd0) begin n_fail++; $display("FAIL rc_rsp got valid=%b z=%0d want 0,0", rsp_valid, rsp_z); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rc_busy got %b want 0", busy); end
        n_cmp++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL rc_ptr got %b want 0001", req_ready); end
        nx(); req_valid = 4'b0000;
        nx(); #1;
        n_cmp++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd0) begin n_fail++; $display("FAIL rc_after got valid=%b id=%0d want 1,0", rsp_valid, rsp_id); end
        nx();
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_wrap();
        test_backpressure();
        test_corners();
        test_reset_calc();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
